// File: rtl/tlb_miss_ctrl.sv
// tlb_miss_ctrl: lookup/refill controller in front of the block-RAM CAM TLB.
// Optional: define TLB_FREE_FIRST_EN to prefer empty slots as refill victims.
module tlb_miss_ctrl #(
    parameter int VPN_WIDTH  = 16,
    parameter int PPN_WIDTH  = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [VPN_WIDTH-1:0]  req_vpn,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [PPN_WIDTH-1:0]  resp_ppn,
    output logic                  miss_valid,
    output logic [VPN_WIDTH-1:0]  miss_vpn,
    input  logic                  refill_valid,
    input  logic [PPN_WIDTH-1:0]  refill_ppn,
    input  logic                  inval_valid,
    input  logic [ADDR_WIDTH-1:0] inval_addr,
    output logic [VPN_WIDTH-1:0]  cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [VPN_WIDTH-1:0]  cam_write_data,
    output logic                  cam_write_enable,
    output logic                  cam_write_delete,
    input  logic                  cam_write_busy
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOKUP, S_MISS, S_WRITE, S_WAIT, S_INVAL
    } state_t;

    state_t state_q, state_d;

    logic [VPN_WIDTH-1:0]  vpn_q, vpn_d;
    logic [PPN_WIDTH-1:0]  refill_q, refill_d;
    logic [ADDR_WIDTH-1:0] victim_q, victim_d;
    logic                  victim_rr_q, victim_rr_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] inval_q, inval_d;
    logic                  is_inval_q, is_inval_d;
    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [PPN_WIDTH-1:0]  resp_ppn_q, resp_ppn_d;
    logic [PPN_WIDTH-1:0]  ppn_ram [ENTRIES];

    logic                  idle_free;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] victim_pick;
    logic                  pick_rr;

    // Idle slot is also closed while a response is on the bus, so a
    // new request is taken the cycle after resp_valid.
    assign idle_free = (state_q == S_IDLE) && !cam_write_busy && !resp_valid_q;

    // A zeroed CAM entry can match; only slots we filled count as hits.
    assign hit = cam_match && valid_q[cam_match_addr];

`ifdef TLB_FREE_FIRST_EN
    // Victim: lowest empty slot, else the round-robin pointer.
    always_comb begin
        victim_pick = ptr_q;
        pick_rr     = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim_pick = ADDR_WIDTH'(i);
                pick_rr     = 1'b0;
            end
        end
    end
`else
    assign victim_pick = ptr_q;
    assign pick_rr     = 1'b1;
`endif

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            vpn_q        <= '0;
            refill_q     <= '0;
            victim_q     <= '0;
            victim_rr_q  <= 1'b0;
            ptr_q        <= '0;
            inval_q      <= '0;
            is_inval_q   <= 1'b0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_ppn_q   <= '0;
        end else begin
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            refill_q     <= refill_d;
            victim_q     <= victim_d;
            victim_rr_q  <= victim_rr_d;
            ptr_q        <= ptr_d;
            inval_q      <= inval_d;
            is_inval_q   <= is_inval_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_ppn_q   <= resp_ppn_d;
        end
    end

    // Physical-page RAM, written alongside the CAM entry.
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE) begin
            ppn_ram[victim_q] <= refill_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:   if (!cam_write_busy) state_d = S_IDLE;
            S_IDLE: begin
                if (idle_free) begin
                    if (inval_valid) begin
                        state_d = S_INVAL;
                    end else if (req_valid) begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: state_d = hit ? S_IDLE : S_MISS;
            S_MISS:   if (refill_valid) state_d = S_WRITE;
            S_WRITE:  state_d = S_WAIT;
            S_WAIT:   if (!cam_write_busy) state_d = S_IDLE;
            S_INVAL:  state_d = S_WAIT;
            default:  state_d = S_INIT;
        endcase
    end

    // Datapath next values: latches, slot bookkeeping, response.
    always_comb begin
        vpn_d        = vpn_q;
        refill_d     = refill_q;
        victim_d     = victim_q;
        victim_rr_d  = victim_rr_q;
        ptr_d        = ptr_q;
        inval_d      = inval_q;
        is_inval_d   = is_inval_q;
        valid_d      = valid_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_ppn_d   = resp_ppn_q;
        unique case (state_q)
            S_IDLE: begin
                if (idle_free) begin
                    if (inval_valid) begin
                        inval_d    = inval_addr;
                        is_inval_d = 1'b1;
                    end else if (req_valid) begin
                        vpn_d      = req_vpn;
                        is_inval_d = 1'b0;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_ppn_d   = ppn_ram[cam_match_addr];
                end
            end
            S_MISS: begin
                if (refill_valid) begin
                    refill_d    = refill_ppn;
                    victim_d    = victim_pick;
                    victim_rr_d = pick_rr;
                end
            end
            S_WRITE: begin
                valid_d[victim_q] = 1'b1;
                if (victim_rr_q) begin
                    ptr_d = victim_q + ADDR_WIDTH'(1);
                end
            end
            S_WAIT: begin
                if (!cam_write_busy && !is_inval_q) begin
                    resp_valid_d = 1'b1;
                    resp_ppn_d   = refill_q;
                end
            end
            S_INVAL: valid_d[inval_q] = 1'b0;
            default: ;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        req_ready        = idle_free;
        resp_valid       = resp_valid_q;
        resp_hit         = resp_hit_q;
        resp_ppn         = resp_ppn_q;
        miss_valid       = (state_q == S_MISS);
        miss_vpn         = vpn_q;
        cam_compare_data = (state_q == S_IDLE) ? req_vpn : vpn_q;
        cam_write_enable = (state_q == S_WRITE);
        cam_write_delete = (state_q == S_INVAL);
        cam_write_addr   = '0;
        cam_write_data   = '0;
        if (state_q == S_WRITE) begin
            cam_write_addr = victim_q;
            cam_write_data = vpn_q;
        end else if (state_q == S_INVAL) begin
            cam_write_addr = inval_q;
        end
    end

endmodule

// File: tb/tb_tlb_miss_ctrl.sv
// tb_tlb_miss_ctrl: table-driven bench with a behavioural CAM model
// and a response scoreboard for tlb_miss_ctrl.
module tb_tlb_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [15:0] req_vpn;
    logic        resp_valid, resp_hit;
    logic [15:0] resp_ppn;
    logic        miss_valid;
    logic [15:0] miss_vpn;
    logic        refill_valid;
    logic [15:0] refill_ppn;
    logic        inval_valid;
    logic [4:0]  inval_addr;
    logic [15:0] cam_compare_data;
    logic        cam_match;
    logic [4:0]  cam_match_addr;
    logic [4:0]  cam_write_addr;
    logic [15:0] cam_write_data;
    logic        cam_write_enable, cam_write_delete, cam_write_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        hit;
        logic [15:0] ppn;
        int          lat;
        int          c0;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [15:0] vpn;
        logic        hit;
        logic [15:0] ppn;
        int          slot;
    } vec_t;
    vec_t tv[$];

    tlb_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ppn(resp_ppn),
        .miss_valid(miss_valid), .miss_vpn(miss_vpn),
        .refill_valid(refill_valid), .refill_ppn(refill_ppn),
        .inval_valid(inval_valid), .inval_addr(inval_addr),
        .cam_compare_data(cam_compare_data),
        .cam_match(cam_match), .cam_match_addr(cam_match_addr),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_write_enable(cam_write_enable),
        .cam_write_delete(cam_write_delete),
        .cam_write_busy(cam_write_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural CAM: registered match, 3-cycle busy per write/delete.
    logic [15:0] cam_vpn [32];
    logic [31:0] cam_vld;
    int          busy_cnt = 0;
    int          last_wr  = -1;

    assign cam_write_busy = (busy_cnt != 0);

    function automatic logic [5:0] cam_lookup(input logic [15:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (cam_vld[i] && cam_vpn[i] == v) r = {1'b1, 5'(i)};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cam_vld  <= '0;
            busy_cnt <= 4;
            cam_match <= 1'b0;
            cam_match_addr <= '0;
        end else begin
            {cam_match, cam_match_addr} <= cam_lookup(cam_compare_data);
            if (cam_write_enable) begin
                cam_vpn[cam_write_addr] <= cam_write_data;
                cam_vld[cam_write_addr] <= 1'b1;
                busy_cnt <= 3;
                last_wr  <= 32'(cam_write_addr);
            end else if (cam_write_delete) begin
                cam_vld[cam_write_addr] <= 1'b0;
                busy_cnt <= 3;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // CAM write-port protocol and response scoreboard.
    always @(negedge clk) begin
        if (!rst && (cam_write_enable || cam_write_delete)) begin
            chk("wr_proto", 32'({cam_write_enable & cam_write_delete,
                                 cam_write_busy}), 32'd0);
        end
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_spurious actual=resp_valid required=none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                chk("resp_ppn", 32'(resp_ppn), 32'(e.ppn));
                if (e.lat != 0) chk("hit_lat", 32'(cyc - e.c0), 32'(e.lat));
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (req_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic [15:0] vpn, input logic hit,
                          input logic [15:0] ppn, input int slot);
        int t;
        int c0;
        exp_t e;
        wait_ready();
        if (req_ready !== 1'b1) return;
        req_vpn   = vpn;
        req_valid = 1'b1;
        c0 = cyc;
        e.hit = hit;
        e.ppn = ppn;
        e.lat = hit ? 2 : 0;
        e.c0  = c0;
        sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (!hit) begin
            t = 0;
            while (miss_valid !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("miss_lat", 32'(cyc - c0), 32'd2);
            chk("miss_vpn", 32'(miss_vpn), 32'(vpn));
            refill_ppn   = ppn;
            refill_valid = 1'b1;
            @(negedge clk);
            refill_valid = 1'b0;
        end
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("resp_timeout", 32'(sbq.size()), 32'd0);
        if (!hit && slot >= 0) chk("victim_slot", 32'(last_wr), 32'(slot));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int c0, t, n;
        int hs[2];
        int slot5;
        exp_t e;

        tv.push_back('{16'h1234, 1'b0, 16'h00AB, 0});
        tv.push_back('{16'h1234, 1'b1, 16'h00AB, -1});
        for (int i = 1; i < 32; i++) begin
            tv.push_back('{16'(16'h0100 + i), 1'b0, 16'(16'h0A00 + i), i});
        end
        tv.push_back('{16'h2000, 1'b0, 16'h0077, 0});
        tv.push_back('{16'h1234, 1'b0, 16'h00CD, 1});
        tv.push_back('{16'h2000, 1'b1, 16'h0077, -1});
        tv.push_back('{16'h0103, 1'b1, 16'h0A03, -1});
        tv.push_back('{16'h1234, 1'b1, 16'h00CD, -1});

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_vpn      = '0;
        refill_valid = 1'b0;
        refill_ppn   = '0;
        inval_valid  = 1'b0;
        inval_addr   = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'(|{req_ready, resp_valid, resp_hit, resp_ppn,
            miss_valid, miss_vpn, cam_compare_data, cam_write_addr,
            cam_write_data, cam_write_enable, cam_write_delete}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_not_ready", 32'(req_ready), 32'd0);
        wait_ready();
        chk("init_busy_done", 32'(cam_write_busy), 32'd0);

        for (int i = 0; i < tv.size(); i++) begin
            do_req(tv[i].vpn, tv[i].hit, tv[i].ppn, tv[i].slot);
        end

        // Back-to-back hits with req_valid held high.
        wait_ready();
        req_vpn   = 16'h2000;
        req_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (req_ready) begin
                e.hit = 1'b1;
                e.ppn = 16'h0077;
                e.lat = 2;
                e.c0  = cyc;
                sbq.push_back(e);
                hs[n] = cyc;
                n++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_count", 32'(n), 32'd2);
        chk("b2b_spacing", 32'(hs[1] - hs[0]), 32'd3);
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_resp", 32'(sbq.size()), 32'd0);

        // Invalidate slot 5 while a request is also offered.
        wait_ready();
        inval_valid = 1'b1;
        inval_addr  = 5'd5;
        req_valid   = 1'b1;
        req_vpn     = 16'h0103;
        c0 = cyc;
        @(negedge clk);
        inval_valid = 1'b0;
        req_valid   = 1'b0;
        chk("inval_delete", 32'(cam_write_delete), 32'd1);
        chk("inval_enable", 32'(cam_write_enable), 32'd0);
        chk("inval_addr", 32'(cam_write_addr), 32'd5);
        wait_ready();
        chk("inval_len", 32'(cyc - c0 >= 3), 32'd1);
`ifdef TLB_FREE_FIRST_EN
        slot5 = 5;
`else
        slot5 = 2;
`endif
        do_req(16'h0105, 1'b0, 16'h0055, slot5);
        do_req(16'h0105, 1'b1, 16'h0055, -1);

        // Reset while waiting for a refill.
        wait_ready();
        req_vpn   = 16'h3000;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (miss_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rm_miss", 32'(miss_valid), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rm_miss_clear", 32'(miss_valid), 32'd0);
        chk("rm_not_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_init", 32'(req_ready), 32'd0);
        do_req(16'h2000, 1'b0, 16'h0088, 0);
        do_req(16'h2000, 1'b1, 16'h0088, -1);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_miss_ctrl.md
# tlb_miss_ctrl

- Lookup/refill controller placed directly in front of the block-RAM CAM TLB in the MSP430 address path.
- Accepts virtual page numbers from the core and drives the CAM compare bus.
- Holds the physical-page RAM indexed by the CAM's match address.
- On a miss: requests a refill, picks a victim slot, programs the CAM through its write/delete handshake, then returns the translation.

## Interface
- VPN_WIDTH, 16: virtual page number width; equals CAM DATA_WIDTH.
- PPN_WIDTH, 16: physical page number width.
- ADDR_WIDTH, 5: log2 of TLB entries; equals CAM ADDR_WIDTH.

Ports:
- clk  in  1  single clock; CAM port b / control side runs on this clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  controller in IDLE and CAM not busy.
- req_vpn  in  VPN_WIDTH  page to translate.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_hit  out  1  1 = served from TLB, 0 = served by refill.
- resp_ppn  out  PPN_WIDTH  translated page.
- miss_valid  out  1  refill request; level, held until refill accepted.
- miss_vpn  out  VPN_WIDTH  page needing refill.
- refill_valid  in  1  refill data present; sampled only while miss_valid=1.
- refill_ppn  in  PPN_WIDTH  refill translation.
- inval_valid  in  1  invalidate request; accepted only in IDLE.
- inval_addr  in  ADDR_WIDTH  slot to invalidate.
- cam_compare_data  out  VPN_WIDTH  to CAM compare_data.
- cam_match  in  1  from CAM match.
- cam_match_addr  in  ADDR_WIDTH  from CAM match_addr.
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr.
- cam_write_data  out  VPN_WIDTH  to CAM write_data.
- cam_write_enable  out  1  to CAM write_enable.
- cam_write_delete  out  1  to CAM write_delete.
- cam_write_busy  in  1  from CAM write_busy.

## Operation
- Reset values:
  - All outputs 0.
  - valid vector cleared; victim pointer 0; state INIT.
- States:
  - INIT: wait for cam_write_busy=0 (CAM zeroing), then go to IDLE.
  - IDLE: req_ready = ~cam_write_busy.
    - inval_valid=1 takes priority over req_valid → INVAL.
    - Otherwise, a req_valid&&req_ready handshake latches req_vpn → LOOKUP.
  - LOOKUP: cam_compare_data holds the latched VPN (held constant outside IDLE).
    - cam_match=1 → register ppn_ram[cam_match_addr] into resp_ppn, pulse resp_valid with resp_hit=1 → IDLE.
    - cam_match=0 → MISS.
  - MISS: miss_valid=1, miss_vpn = latched VPN.
    - refill_valid=1 → latch refill_ppn, capture the victim → WRITE.
  - WRITE: for exactly one cycle, cam_write_enable=1, cam_write_delete=0, cam_write_addr=victim, cam_write_data=VPN.
    - Same cycle: ppn_ram[victim] ← refill_ppn, valid[victim] ← 1, pointer ← victim+1 (wraps mod 2^ADDR_WIDTH) → WAIT.
  - WAIT: at least one cycle; leave when cam_write_busy=0.
    - Pulse resp_valid, resp_hit=0, resp_ppn = refill_ppn → IDLE.
  - INVAL: for one cycle, cam_write_delete=1, cam_write_enable=0, cam_write_addr=inval_addr; valid[inval_addr] ← 0 → WAIT (no resp pulse for an invalidate).
- cam_write_enable and cam_write_delete are never asserted together, and never while cam_write_busy=1.
- Requests are not accepted outside IDLE; resp_valid fires exactly once per accepted request.
- rst in any state aborts the operation; no response is issued. The parent also resets the CAM.

## Timing
- Hit latency: handshake at cycle 0, match sampled at cycle 1, resp_valid at cycle 2.
- Miss:
  - miss_valid rises at cycle 2.
  - refill_valid sampled at cycle R → WRITE at R+1 → WAIT from R+2.
  - CAM write completes ~3 cycles later; resp_valid follows the first WAIT cycle with busy=0.
- Back-to-back hits: req_ready re-asserts the cycle after resp_valid → one request per 3 cycles.
- Invalidate: IDLE → INVAL → WAIT → IDLE, ≥3 cycles.

## Configuration
- TLB_FREE_FIRST_EN defined:
  - Victim is the lowest-index slot with valid=0.
  - If all slots are valid, the victim is the round-robin pointer.
  - The pointer advances only on a round-robin choice.
- Undefined: victim is always the round-robin pointer; the valid vector is still maintained.

## Test plan
- Reset, then wait for CAM init: req_ready=0 until cam_write_busy falls; all outputs 0.
- Miss then refill: req_vpn=0x1234 → miss_valid=1, miss_vpn=0x1234; refill_ppn=0x00AB → slot 0 written, resp_valid, hit=0, ppn=0x00AB.
- Repeat 0x1234 → resp_valid at cycle 2, hit=1, ppn=0x00AB.
- Fill all 32 slots, then 33rd miss (0x2000, ppn 0x0077) → slot 0 overwritten; old VPN now misses; 0x2000 hits with 0x0077.
- Invalidate slot 5 (VPN 0x0105) with simultaneous req_valid → delete wins; later 0x0105 misses. With TLB_FREE_FIRST_EN, the next refill lands in slot 5.
- Assert rst during MISS → no resp_valid, miss_valid=0, state INIT; a subsequent lookup of any VPN misses.
